// File: rtl/karatsuba_operand_loader.sv
// karatsuba_operand_loader: packs a stream of (a[k], b[k]) pairs into
// flat D*N operand buses for karatsuba_negacyclic_conv.
module karatsuba_operand_loader #(
    parameter int N = 17,
    parameter int D = 32,
    localparam int CW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [D-1:0]     in_a,
    input  logic [D-1:0]     in_b,
    input  logic             in_last,
    output logic [D*N-1:0]   a_out,
    output logic [D*N-1:0]   b_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    coef_cnt,
    output logic             err_short,
    output logic             err_long
);

    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    logic [0:0] state;

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == FULL);

    // Frame packing FSM: fill slots in LOAD, hold the frame in FULL
    // until the consumer takes it, then clear for the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            coef_cnt  <= '0;
            a_out     <= '0;
            b_out     <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        for (int k = 0; k < N; k++) begin
                            if (coef_cnt == CW'(k)) begin
                                a_out[D*k +: D] <= in_a;
                                b_out[D*k +: D] <= in_b;
                            end
                        end
                        coef_cnt <= coef_cnt + CW'(1);
                        if (coef_cnt == LAST_IDX) begin
                            state    <= FULL;
                            err_long <= ~in_last;
                        end else if (in_last) begin
                            // Short frame: upper slots are still zero
                            // from the clear on entry to LOAD.
                            state     <= FULL;
                            err_short <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state    <= LOAD;
                        coef_cnt <= '0;
                        a_out    <= '0;
                        b_out    <= '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_karatsuba_operand_loader.sv
// tb_karatsuba_operand_loader: directed checks of frame packing,
// backpressure, short/long frames, reset and back-to-back streaming.
module tb_karatsuba_operand_loader;

    localparam int N  = 17;
    localparam int D  = 32;
    localparam int CW = $clog2(N + 1);
    localparam int W  = D * N;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [D-1:0]  in_a;
    logic [D-1:0]  in_b;
    logic          in_last;
    logic [W-1:0]  a_out;
    logic [W-1:0]  b_out;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] coef_cnt;
    logic          err_short;
    logic          err_long;

    karatsuba_operand_loader #(.N(N), .D(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .a_out     (a_out),
        .b_out     (b_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .coef_cnt  (coef_cnt),
        .err_short (err_short),
        .err_long  (err_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_short = 0;
    int n_long = 0;

    // Count error pulses away from the clock edge.
    always @(negedge clk) begin
        if (err_short) n_short++;
        if (err_long) n_long++;
    end

    task automatic chk(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [D-1:0] a,
                        input logic [D-1:0] b,
                        input logic last);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_last = last;
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    function automatic logic [D-1:0] pa(input int fr, input int k);
        return D'(fr * 1000 + k + 7);
    endfunction

    function automatic logic [D-1:0] pb(input int fr, input int k);
        return D'(32'hBEEF0000 + fr * 77 + k * 5);
    endfunction

    task automatic run6(input bit gaps);
        int idx = 0;
        int afr = 0;
        int fr = 0;
        int cyc = 0;
        int last_cyc = -1;
        bit acc;
        bit v;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        out_ready = 1'b1;
        while (fr < 3 && cyc < 400) begin
            v = (afr < 3) && (gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
            in_valid = v;
            in_a = v ? pa(afr, idx) : D'($urandom);
            in_b = v ? pb(afr, idx) : D'($urandom);
            in_last = v && (idx == N - 1);
            acc = in_valid && in_ready;
            step();
            cyc++;
            if (acc) begin
                if (idx == N - 1) begin
                    idx = 0;
                    afr++;
                end else begin
                    idx++;
                end
            end
            if (out_valid) begin
                for (int k = 0; k < N; k++) begin
                    ea[D*k +: D] = pa(fr, k);
                    eb[D*k +: D] = pb(fr, k);
                end
                chk("t6 a_out", a_out, ea);
                chk("t6 b_out", b_out, eb);
                chk("t6 in_ready hs", W'(in_ready), W'(0));
                if (!gaps && last_cyc >= 0)
                    chk("t6 spacing", W'(cyc - last_cyc), W'(N + 1));
                last_cyc = cyc;
                fr++;
            end
        end
        chk("t6 frames", W'(fr), W'(3));
        in_valid = 1'b0;
        in_last = 1'b0;
        step();
        out_ready = 1'b0;
    endtask

    logic [W-1:0] ea;
    logic [W-1:0] eb;
    int unstable;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst a_out", a_out, '0);
        chk("rst b_out", b_out, '0);
        chk("rst out_valid", W'(out_valid), W'(0));
        chk("rst coef_cnt", W'(coef_cnt), W'(0));
        chk("rst errs", W'({err_short, err_long}), W'(0));
        rst_n = 1'b1;
        step();
        chk("rst in_ready", W'(in_ready), W'(1));

        // 1: full frame
        n_short = 0;
        n_long = 0;
        for (int k = 0; k < N; k++) begin
            ea[D*k +: D] = D'(k + 1);
            eb[D*k +: D] = D'(2 * k);
        end
        for (int k = 0; k < N; k++) begin
            chk("t1 out_valid early", W'(out_valid), W'(0));
            send(D'(k + 1), D'(2 * k), k == N - 1);
        end
        chk("t1 out_valid", W'(out_valid), W'(1));
        chk("t1 a_out", a_out, ea);
        chk("t1 b_out", b_out, eb);
        chk("t1 coef_cnt", W'(coef_cnt), W'(17));

        // 2: backpressure
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_out !== ea || b_out !== eb || !out_valid || in_ready)
                unstable++;
        end
        chk("t1 errs", W'(n_short + n_long), W'(0));
        chk("t2 held", W'(unstable), W'(0));
        handshake();
        chk("t2 in_ready", W'(in_ready), W'(1));
        chk("t2 out_valid", W'(out_valid), W'(0));
        chk("t2 a_out clr", a_out, '0);
        chk("t2 b_out clr", b_out, '0);
        chk("t2 coef_cnt", W'(coef_cnt), W'(0));

        // 3: short frame
        n_short = 0;
        n_long = 0;
        ea = '0;
        eb = '0;
        for (int k = 0; k < 5; k++) begin
            ea[D*k +: D] = 32'hFFFFFFFF;
            eb[D*k +: D] = D'(k);
            send(32'hFFFFFFFF, D'(k), k == 4);
        end
        chk("t3 out_valid", W'(out_valid), W'(1));
        chk("t3 err_short", W'(err_short), W'(1));
        chk("t3 err_long", W'(err_long), W'(0));
        chk("t3 coef_cnt", W'(coef_cnt), W'(5));
        chk("t3 a_out", a_out, ea);
        chk("t3 b_out", b_out, eb);
        step();
        chk("t3 pulse end", W'(err_short), W'(0));
        chk("t3 n_short", W'(n_short), W'(1));
        chk("t3 n_long", W'(n_long), W'(0));
        handshake();

        // 4: long frame
        n_short = 0;
        n_long = 0;
        for (int k = 0; k < N; k++) begin
            ea[D*k +: D] = D'(32'hA5A50000 + k);
            eb[D*k +: D] = ~D'(32'hA5A50000 + k);
            send(D'(32'hA5A50000 + k), ~D'(32'hA5A50000 + k), 1'b0);
        end
        chk("t4 out_valid", W'(out_valid), W'(1));
        chk("t4 err_long", W'(err_long), W'(1));
        chk("t4 coef_cnt", W'(coef_cnt), W'(17));
        chk("t4 a_out", a_out, ea);
        chk("t4 b_out", b_out, eb);
        step();
        chk("t4 n_long", W'(n_long), W'(1));
        chk("t4 n_short", W'(n_short), W'(0));
        handshake();

        // 5: reset mid-frame, then a short fresh frame
        for (int k = 0; k < 8; k++)
            send(D'(32'hDEAD0000 + k), D'(32'hCAFE0000 + k), 1'b0);
        chk("t5 cnt pre", W'(coef_cnt), W'(8));
        rst_n = 1'b0;
        step();
        chk("t5 a_out", a_out, '0);
        chk("t5 b_out", b_out, '0);
        chk("t5 coef_cnt", W'(coef_cnt), W'(0));
        chk("t5 out_valid", W'(out_valid), W'(0));
        rst_n = 1'b1;
        ea = '0;
        eb = '0;
        for (int k = 0; k < 4; k++) begin
            ea[D*k +: D] = D'(3 * k + 1);
            eb[D*k +: D] = D'(32'h100 + k);
            send(D'(3 * k + 1), D'(32'h100 + k), k == 3);
        end
        chk("t5 fresh a", a_out, ea);
        chk("t5 fresh b", b_out, eb);
        chk("t5 fresh cnt", W'(coef_cnt), W'(4));
        handshake();

        // 6: back-to-back, then with random input gaps
        n_short = 0;
        n_long = 0;
        run6(1'b0);
        run6(1'b1);
        chk("t6 errs", W'(n_short + n_long), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
